calculate_voltage_control: RTL
==============================

# calculate_voltage_control

Moore controller that sequences the node-voltage calculation datapath through its five-phase handshake: data reset, node choose, node check, ops, and memory load. It walks every nodeHeads entry once per run, skips invalid nodes, and reports completion. A per-phase watchdog flags a stalled datapath. It sits between the top-level run/start logic and the voltage datapath. It owns no RAM or arithmetic.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles any phase may wait for its done handshake before error (≥ 70, since ops take 64 cycles).
- CW, 8: watchdog counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  level; begin a run from IDLE, DONE or ERROR.
- data_reset_done  in  1  datapath reset complete.
- node_chosen  in  1  datapath latched next nodeHeads address.
- all_done  in  1  datapath index wrapped; current chosen node is the last.
- node_checked  in  1  node validity sampled.
- node_valid  in  1  validity of checked node; qualified by node_checked.
- ops_done  in  1  voltage computed, write data/wren presented.
- memory_loaded  in  1  write phase finished.
- go_reset_data, go_choose_node, go_check_node, go_do_ops, ld_memory  out  1 each  phase requests, exactly one high in its state.
- busy  out  1  high in any state other than IDLE, DONE or ERROR.
- done  out  1  high in DONE.
- error  out  1  high in ERROR.
- visited_count  out  6  nodes checked this run (0–32).
- valid_count  out  6  nodes written this run (0–32).

## Operation
- States: IDLE, RESET, CHOOSE, CHECK, OPS, LOAD, DONE, ERROR. Outputs are decoded from the state register only; there are no combinational input-to-output paths.
- IDLE: start → RESET.
- RESET drives go_reset_data. On data_reset_done → CHOOSE. On entry, clear both counters and last_node.
- CHOOSE drives go_choose_node.
  - node_chosen → CHECK, latching last_node ← all_done.
  - all_done & ~node_chosen → DONE. This is a defensive path and node_chosen has priority over it.
- CHECK drives go_check_node. On node_checked, increment visited_count, then:
  - node_valid=1 → OPS.
  - node_valid=0 → DONE if last_node, else CHOOSE.
- OPS drives go_do_ops. ops_done → LOAD.
- LOAD drives ld_memory. On memory_loaded, increment valid_count, then go to DONE if last_node, else CHOOSE.
- DONE: done=1 and counters hold. start → RESET.
- ERROR: error=1 and counters hold. start → RESET.
- Watchdog:
  - Clears on every state change.
  - Increments each cycle while in RESET through LOAD, saturating at TIMEOUT.
  - Reaching TIMEOUT with the awaited handshake still low → ERROR.
  - Handshake and timeout in the same cycle: the handshake wins.
- Counters saturate at 32. A wider value is never produced.

## Timing
- Reset (resetn=0, async): state=IDLE, all go_*/ld_memory=0, busy=0, done=0, error=0, counters=0, last_node=0, watchdog=0.
- Handshakes are sampled at the edge. When a done input is seen high at edge N, the state changes at edge N, so the request drops in cycle N+1. Each request therefore stays high one cycle past the done flag; the datapath tolerates this.
- Run latency = 1 (IDLE→RESET) + reset phase + per-node phases. Control overhead is 1 cycle per phase transition.
- start held high in DONE immediately restarts the run. The top level must drop start to get a single run.
- resetn asserted mid-phase forces IDLE within the same cycle. The datapath is re-cleared by the next RESET phase.
- A stray handshake input high in a state that does not await it is ignored.

## Test plan
- Full run, 32 nodes all valid, ideal datapath model (ops_done 64 cycles after go_do_ops):
  - done=1, valid_count=32, visited_count=32.
  - The node with all_done=1 at choose still passes through OPS and LOAD.
- Alternating validity (even nodes valid) → valid_count=16, visited_count=32. Invalid nodes go CHECK→CHOOSE with go_do_ops never high.
- Last node invalid: all_done with node_chosen at node 31 and node_valid=0 → CHECK→DONE directly, visited_count=32.
- Stall: hold ops_done=0 → error=1 exactly TIMEOUT=255 cycles after OPS entry. go_do_ops=0 in ERROR. start → RESET with counters cleared.
- Async reset mid-OPS: resetn=0 with no clock edge → all outputs 0 immediately. Release resetn, pulse start → fresh run completes with correct counts.
- Boundary: ops_done rising on the cycle the watchdog hits 255 → transition to LOAD, no error.

Source files
------------

// File: rtl/calculate_voltage_control.sv
// Sequencer for the node-voltage datapath: walks every nodeHeads entry through
// reset/choose/check/ops/load handshakes, with a per-phase stall watchdog.
module calculate_voltage_control #(
   parameter int TIMEOUT = 255,
   parameter int CW      = 8
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       data_reset_done,
   input  logic       node_chosen,
   input  logic       all_done,
   input  logic       node_checked,
   input  logic       node_valid,
   input  logic       ops_done,
   input  logic       memory_loaded,
   output logic       go_reset_data,
   output logic       go_choose_node,
   output logic       go_check_node,
   output logic       go_do_ops,
   output logic       ld_memory,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [5:0] visited_count,
   output logic [5:0] valid_count
);

   // state  | meaning
   // IDLE   | waiting for start after reset
   // RESET  | datapath clearing its state
   // CHOOSE | datapath latching next nodeHeads address
   // CHECK  | datapath sampling node validity
   // OPS    | datapath computing node voltage
   // LOAD   | datapath writing result to memory
   // DONE   | run finished, counters held
   // ERROR  | a phase stalled past TIMEOUT, counters held
   typedef enum logic [2:0] {
      S_IDLE, S_RESET, S_CHOOSE, S_CHECK, S_OPS, S_LOAD, S_DONE, S_ERROR
   } state_t;

   localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT - 1);
   localparam logic [5:0]    CNT_MAX  = 6'd32;

   state_t        state;
   logic [CW-1:0] wd_count;
   logic          last_node;
   logic          phase_active;
   logic          handshake;
   logic          timed_out;

   function automatic logic [5:0] sat_inc(input logic [5:0] c);
      return (c >= CNT_MAX) ? CNT_MAX : c + 6'd1;
   endfunction

   // CHOOSE can also leave on the defensive all_done path, so it counts as its handshake.
   always_comb begin
      handshake = 1'b0;
      case (state)
         S_RESET:  handshake = data_reset_done;
         S_CHOOSE: handshake = node_chosen | all_done;
         S_CHECK:  handshake = node_checked;
         S_OPS:    handshake = ops_done;
         S_LOAD:   handshake = memory_loaded;
         default:  handshake = 1'b0;
      endcase
   end

   assign phase_active = (state == S_RESET) || (state == S_CHOOSE) || (state == S_CHECK) ||
                         (state == S_OPS)   || (state == S_LOAD);
   assign timed_out    = (wd_count == WD_LIMIT);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= S_IDLE;
         wd_count      <= '0;
         last_node     <= 1'b0;
         visited_count <= '0;
         valid_count   <= '0;
      end else begin
         if (phase_active && !handshake) begin
            if (timed_out) begin
               state    <= S_ERROR;
               wd_count <= '0;
            end else begin
               wd_count <= wd_count + 1'b1;
            end
         end else begin
            wd_count <= '0;
         end

         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state         <= S_RESET;
                  last_node     <= 1'b0;
                  visited_count <= '0;
                  valid_count   <= '0;
               end
            end
            S_RESET: if (data_reset_done) state <= S_CHOOSE;
            S_CHOOSE: begin
               if (node_chosen) begin
                  state     <= S_CHECK;
                  last_node <= all_done;
               end else if (all_done) begin
                  state <= S_DONE;
               end
            end
            S_CHECK: begin
               if (node_checked) begin
                  visited_count <= sat_inc(visited_count);
                  if (node_valid)     state <= S_OPS;
                  else if (last_node) state <= S_DONE;
                  else                state <= S_CHOOSE;
               end
            end
            S_OPS: if (ops_done) state <= S_LOAD;
            S_LOAD: begin
               if (memory_loaded) begin
                  valid_count <= sat_inc(valid_count);
                  state       <= last_node ? S_DONE : S_CHOOSE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign go_reset_data  = (state == S_RESET);
   assign go_choose_node = (state == S_CHOOSE);
   assign go_check_node  = (state == S_CHECK);
   assign go_do_ops      = (state == S_OPS);
   assign ld_memory      = (state == S_LOAD);
   assign busy           = phase_active;
   assign done           = (state == S_DONE);
   assign error          = (state == S_ERROR);

endmodule
